// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the streaming popcount engine.
package popcount_pkg;

  // Per-frame counting mode, sampled on the first beat of a frame.
  typedef enum logic {
    MODE_WORD  = 1'b0,
    MODE_FRAME = 1'b1
  } mode_e;

  // Frame tracker: once a multi-beat frame starts, the mode input is ignored.
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_e;

  // Number of bits needed to hold a count of 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/popcount_stream_if.sv
// Stream bundle for popcount_stream: input beat handshake, XOR controls and
// result handshake. The engine uses the slave view, the data source/consumer
// side uses the master view.
interface popcount_stream_if #(
  parameter int DATA_W = 64,
  parameter int ACC_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              mode;
  logic              xor_en;
  logic [DATA_W-1:0] pattern;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_count;
  logic              out_sat;

  modport master (
    output in_valid, in_data, in_last, mode, xor_en, pattern, out_ready,
    input  in_ready, out_valid, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, mode, xor_en, pattern, out_ready,
    output in_ready, out_valid, out_count, out_sat
  );
endinterface

// File: rtl/popcount_chunk.sv
// Combinational set-bit counter for one W-bit chunk of the input word.
module popcount_chunk
  import popcount_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]         i_bits,
  output logic [cnt_w(W)-1:0]  o_count
);
  localparam int CW = cnt_w(W);

  // Ripple count of the chunk; kept narrow so the chunk fits one LUT cascade.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/popcount_stream.sv
// Three-stage pipelined popcount / Hamming-distance engine with an optional
// saturating per-frame accumulator.
//   S1: chunk counts of (data ^ pattern?)  S2: word sum  S3: output/accumulate
// The whole pipeline freezes when the output register holds a result that
// the consumer has not taken, so in_ready is simply the inverse of that stall.
module popcount_stream
  import popcount_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 16,
  parameter int ACC_W   = 32
) (
  input logic              clk,
  input logic              rst_n,
  popcount_stream_if.slave bus
);
  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int CCW    = cnt_w(CHUNK_W);
  localparam int SW     = cnt_w(DATA_W);
  localparam int LVLS   = $clog2(NCHUNK);
  localparam int NLEAF  = 1 << LVLS;
  localparam int AW1    = ACC_W + 1;

  // Handshake
  logic w_stall;
  logic w_advance;
  logic w_accept;
  logic r_init_done;

  // Frame tracker
  state_e r_state;
  state_e w_state_next;
  mode_e  w_mode_in;
  logic   w_beat_frame;

  // S1
  logic [DATA_W-1:0] w_word;
  logic [CCW-1:0]    w_chunk_cnt [NCHUNK];
  logic [CCW-1:0]    r_s1_cnt    [NCHUNK];
  logic              r_s1_valid;
  logic              r_s1_frame;
  logic              r_s1_last;

  // S2
  logic [SW-1:0] w_s2_sum;
  logic [SW-1:0] r_s2_sum;
  logic          r_s2_valid;
  logic          r_s2_frame;
  logic          r_s2_last;

  // S3 / accumulator
  logic [ACC_W-1:0] r_acc;
  logic             r_acc_sat;
  logic [AW1-1:0]   w_acc_sum;
  logic             w_acc_ovf;
  logic [ACC_W-1:0] w_acc_clamped;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_count;
  logic             r_out_sat;

  // ---------------------------------------------------------------------
  // Handshake: a held, unaccepted result freezes every stage.
  // r_init_done keeps in_ready low until the first edge after reset release.
  // ---------------------------------------------------------------------
  assign w_stall      = r_out_valid && !bus.out_ready;
  assign w_advance    = !w_stall;
  assign bus.in_ready = r_init_done && w_advance;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Mark the engine ready one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Frame tracker: mode is honoured only on the first beat of a frame.
  // ---------------------------------------------------------------------
  assign w_mode_in    = mode_e'(bus.mode);
  assign w_beat_frame = (r_state == ST_IN_FRAME) || (w_mode_in == MODE_FRAME);

  // State register for the frame tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: single-beat frames never leave IDLE.
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_mode_in == MODE_FRAME && !bus.in_last) begin
            w_state_next = ST_IN_FRAME;
          end
        end
        ST_IN_FRAME: begin
          if (bus.in_last) begin
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // S1: optional XOR against the pattern, then per-chunk counts.
  // pattern is only changed while the pipeline is empty, so no staging.
  // ---------------------------------------------------------------------
  assign w_word = bus.xor_en ? (bus.in_data ^ bus.pattern) : bus.in_data;

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    popcount_chunk #(
      .W (CHUNK_W)
    ) u_chunk (
      .i_bits  (w_word[gi*CHUNK_W +: CHUNK_W]),
      .o_count (w_chunk_cnt[gi])
    );
  end

  // S1 register: chunk counts plus the beat's effective mode and last flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_frame <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int i = 0; i < NCHUNK; i++) begin
        r_s1_cnt[i] <= '0;
      end
    end else if (w_advance) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_frame <= w_beat_frame;
        r_s1_last  <= bus.in_last;
        for (int i = 0; i < NCHUNK; i++) begin
          r_s1_cnt[i] <= w_chunk_cnt[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // S2: balanced adder tree over the chunk counts. Leaves beyond NCHUNK
  // (non-power-of-two chunk counts) are tied to zero.
  // ---------------------------------------------------------------------
  for (genvar gl = 0; gl <= LVLS; gl++) begin : g_lvl
    localparam int N = NLEAF >> gl;
    logic [SW-1:0] w_node [N];
    for (genvar gi = 0; gi < N; gi++) begin : g_node
      if (gl == 0) begin : g_leaf
        if (gi < NCHUNK) begin : g_used
          assign w_node[gi] = SW'(r_s1_cnt[gi]);
        end else begin : g_pad
          assign w_node[gi] = '0;
        end
      end else begin : g_add
        assign w_node[gi] = g_lvl[gl-1].w_node[2*gi] + g_lvl[gl-1].w_node[2*gi+1];
      end
    end
  end

  assign w_s2_sum = g_lvl[LVLS].w_node[0];

  // S2 register: word sum travelling with its mode and last flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_frame <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_sum   <= '0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      r_s2_frame <= r_s1_frame;
      r_s2_last  <= r_s1_last;
      r_s2_sum   <= w_s2_sum;
    end
  end

  // ---------------------------------------------------------------------
  // S3: saturating accumulate on the S2->S3 transfer. The extra carry bit
  // detects overflow; the result clamps at all-ones and never wraps.
  // ---------------------------------------------------------------------
  assign w_acc_sum     = {1'b0, r_acc} + AW1'(r_s2_sum);
  assign w_acc_ovf     = w_acc_sum[ACC_W];
  assign w_acc_clamped = w_acc_ovf ? '1 : w_acc_sum[ACC_W-1:0];

  // Output register and frame accumulator; only word beats and frame-last
  // beats raise out_valid, other frame beats become bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
      r_acc       <= '0;
      r_acc_sat   <= 1'b0;
    end else if (w_advance) begin
      if (!r_s2_valid) begin
        r_out_valid <= 1'b0;
      end else if (!r_s2_frame) begin
        r_out_valid <= 1'b1;
        r_out_count <= ACC_W'(r_s2_sum);
        r_out_sat   <= 1'b0;
      end else if (r_s2_last) begin
        r_out_valid <= 1'b1;
        r_out_count <= w_acc_clamped;
        r_out_sat   <= r_acc_sat | w_acc_ovf;
        r_acc       <= '0;
        r_acc_sat   <= 1'b0;
      end else begin
        r_out_valid <= 1'b0;
        r_acc       <= w_acc_clamped;
        r_acc_sat   <= r_acc_sat | w_acc_ovf;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_count = r_out_count;
  assign bus.out_sat   = r_out_sat;

endmodule
